// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_pkg;
    localparam int   CLKS_PER_BIT_DEFAULT = 417;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   DATA_BITS            = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;
endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer; LSB first, each bit held CLKS_PER_BIT cycles.
// Latency: load seen in IDLE or on the last STOP cycle -> start bit on the next edge.
// Backpressure: load is only honoured when idle or when done is high.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] byte_in,
    output logic                 ser_out,
    output logic                 done
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ser_out_q, ser_out_d;
    logic                 baud_last;
    logic [BAUD_W-1:0]    baud_inc;

    assign baud_last = (baud_q == BAUD_LAST);
    assign baud_inc  = baud_last ? '0 : baud_q + BAUD_W'(1);
    assign done      = (state_q == ST_STOP) && baud_last;
    assign ser_out   = ser_out_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        ser_out_d = ser_out_q;
        unique case (state_q)
            ST_IDLE: begin
                baud_d    = '0;
                ser_out_d = STOP_BIT;
                if (load) begin
                    data_d    = byte_in;
                    state_d   = ST_START;
                    ser_out_d = START_BIT;
                end
            end
            ST_START: begin
                baud_d = baud_inc;
                if (baud_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    ser_out_d = data_q[0];
                end
            end
            ST_DATA: begin
                baud_d = baud_inc;
                if (baud_last) begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d   = ST_STOP;
                        ser_out_d = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        ser_out_d = data_q[bit_idx_q + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_inc;
                // A load here chains the next character with no idle gap.
                if (baud_last) begin
                    if (load) begin
                        data_d    = byte_in;
                        state_d   = ST_START;
                        ser_out_d = START_BIT;
                    end else begin
                        state_d   = ST_IDLE;
                        ser_out_d = STOP_BIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            ser_out_q <= STOP_BIT;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            ser_out_q <= ser_out_d;
        end
    end
endmodule

// File: rtl/uart_frame_tx.sv
// Latches a multi-byte word on start_tx and sends it MSB byte first as back-to-back 8N1 chars.
// Latency: start bit one edge after acceptance; tx_finish N*10*CLKS_PER_BIT edges after that.
// Backpressure: start_tx is ignored (not queued) while a frame is in flight.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int bytes_to_transmit = 2,
    parameter int CLKS_PER_BIT      = CLKS_PER_BIT_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [bytes_to_transmit*8-1:0]   ciphertext,
    input  logic                             start_tx,
    output logic                             ser_out,
    output logic                             tx_busy,
    output logic                             tx_finish
);
    localparam int               W        = bytes_to_transmit * DATA_BITS;
    localparam int               IDX_W    = $clog2(bytes_to_transmit) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(bytes_to_transmit - 1);

    logic [W-1:0]         frame_q, frame_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic                 active_q, active_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_finish_q, tx_finish_d;
    logic                 byte_load;
    logic [DATA_BITS-1:0] byte_dat;
    logic                 byte_done;

    // The frame register shifts left per byte, so its top byte is always the next one to send.
    always_comb begin
        frame_d     = frame_q;
        byte_idx_d  = byte_idx_q;
        active_d    = active_q;
        tx_busy_d   = active_q;
        tx_finish_d = 1'b0;
        byte_load   = 1'b0;
        byte_dat    = frame_q[W-1 -: DATA_BITS];
        if (!active_q) begin
            if (start_tx) begin
                frame_d    = ciphertext << DATA_BITS;
                byte_idx_d = '0;
                active_d   = 1'b1;
                tx_busy_d  = 1'b1;
                byte_load  = 1'b1;
                byte_dat   = ciphertext[W-1 -: DATA_BITS];
            end
        end else if (byte_done) begin
            if (byte_idx_q < LAST_IDX) begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
                frame_d    = frame_q << DATA_BITS;
                byte_load  = 1'b1;
            end else begin
                active_d    = 1'b0;
                tx_finish_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q     <= '0;
            byte_idx_q  <= '0;
            active_q    <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_finish_q <= 1'b0;
        end else begin
            frame_q     <= frame_d;
            byte_idx_q  <= byte_idx_d;
            active_q    <= active_d;
            tx_busy_q   <= tx_busy_d;
            tx_finish_q <= tx_finish_d;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .reset   (reset),
        .load    (byte_load),
        .byte_in (byte_dat),
        .ser_out (ser_out),
        .done    (byte_done)
    );

    assign tx_busy   = tx_busy_q;
    assign tx_finish = tx_finish_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: a 2-byte/4-clock instance and a 16-byte/2-clock instance.
module tb_uart_frame_tx;
    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  cipher_a;
    logic         start_a;
    logic         ser_a, busy_a, fin_a;
    logic [127:0] cipher_b;
    logic         start_b;
    logic         ser_b, busy_b, fin_b;

    int           tests = 0;
    int           fails = 0;
    logic         exp_q[$];
    logic [7:0]   exp_bytes[$];

    logic [127:0] word_b, got_b;
    logic         cap[1:420];
    logic [7:0]   rx_byte;
    logic         exp_bit;
    int           nfin, fin_at, p, pos, f, rel;

    always #5 clk = ~clk;

    uart_frame_tx #(.bytes_to_transmit(2), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset), .ciphertext(cipher_a), .start_tx(start_a),
        .ser_out(ser_a), .tx_busy(busy_a), .tx_finish(fin_a)
    );

    uart_frame_tx #(.bytes_to_transmit(16), .CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .reset(reset), .ciphertext(cipher_b), .start_tx(start_b),
        .ser_out(ser_b), .tx_busy(busy_b), .tx_finish(fin_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [127:0] word, input int nbytes);
        logic [7:0] b;
        for (int i = nbytes - 1; i >= 0; i--) begin
            b = word[8*i +: 8];
            exp_q.push_back(1'b0);
            for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
            exp_q.push_back(1'b1);
        end
    endtask

    // Start a frame on dut_a right after edge 0, optionally pulse start_tx again and change ciphertext.
    task automatic run_frame_a(input logic [15:0] word, input int restart_at, input int chg_at,
                               input logic [15:0] chg_val, input string tag);
        int   n;
        logic b;
        push_frame({112'd0, word}, 2);
        cipher_a = word;
        start_a  = 1'b1;
        n        = 0;
        for (int e = 1; e <= 90; e++) begin
            tick();
            start_a = (e == restart_at);
            if (e == chg_at) cipher_a = chg_val;
            if (e == 1) begin
                check1({tag, " start_bit"}, ser_a, 1'b0);
                check1({tag, " busy_rise"}, busy_a, 1'b1);
            end
            if (e >= 2 && e <= 78 && (e - 2) % 4 == 0) begin
                b = exp_q.pop_front();
                check1({tag, " bit"}, ser_a, b);
            end
            if (fin_a) n++;
            if (e == 81) begin
                check1({tag, " finish"}, fin_a, 1'b1);
                check1({tag, " busy_fin"}, busy_a, 1'b1);
            end
            if (e == 82) check1({tag, " busy_fall"}, busy_a, 1'b0);
        end
        checkn({tag, " finish_count"}, 128'(n), 128'd1);
        check1({tag, " idle_line"}, ser_a, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        cipher_a = '0;
        cipher_b = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state and quiet idle line
        check1("rst ser_b", ser_b, 1'b1);
        check1("rst busy_b", busy_b, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check1("idle ser", ser_a, 1'b1);
            check1("idle busy", busy_a, 1'b0);
            check1("idle fin", fin_a, 1'b0);
        end

        run_frame_a(16'hA53C, -1, -1, 16'h0000, "basic");
        run_frame_a(16'hA53C, 40, 5, 16'hFFFF, "ignore");
        run_frame_a(16'h5A81, -1, -1, 16'h0000, "alt");

        // start_tx held high: back-to-back frames with one idle cycle between
        push_frame(128'h0001, 2);
        push_frame(128'h0001, 2);
        cipher_a = 16'h0001;
        start_a  = 1'b1;
        nfin     = 0;
        for (int e = 1; e <= 170; e++) begin
            tick();
            if (e == 100) start_a = 1'b0;
            f   = (e >= 82) ? 1 : 0;
            rel = e - 81 * f;
            if (rel >= 2 && rel <= 78 && (rel - 2) % 4 == 0) begin
                exp_bit = exp_q.pop_front();
                check1("held bit", ser_a, exp_bit);
            end
            if (fin_a) nfin++;
            if (e == 81) begin
                check1("held fin1", fin_a, 1'b1);
                check1("held gap_ser", ser_a, 1'b1);
            end
            if (e == 82) begin
                check1("held restart_ser", ser_a, 1'b0);
                check1("held restart_fin", fin_a, 1'b0);
                check1("held restart_busy", busy_a, 1'b1);
            end
            if (e == 162) check1("held fin2", fin_a, 1'b1);
            if (e == 163) check1("held busy_fall", busy_a, 1'b0);
        end
        checkn("held finish_count", 128'(nfin), 128'd2);

        // Reset mid-frame abandons the frame without tx_finish
        cipher_a = 16'hA53C;
        start_a  = 1'b1;
        nfin     = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            start_a = 1'b0;
            if (e == 30) reset = 1'b1;
            if (e == 31) begin
                reset = 1'b0;
                check1("rst_mid ser", ser_a, 1'b1);
                check1("rst_mid busy", busy_a, 1'b0);
            end
            if (fin_a) nfin++;
        end
        checkn("rst_mid no_finish", 128'(nfin), 128'd0);
        run_frame_a(16'hC3E7, -1, -1, 16'h0000, "after_rst");

        // Wide instance: capture the line, then decode it with an 8N1 receiver
        word_b = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 15; i >= 0; i--) exp_bytes.push_back(word_b[8*i +: 8]);
        for (int i = 1; i <= 420; i++) cap[i] = 1'b1;
        cipher_b = word_b;
        start_b  = 1'b1;
        nfin     = 0;
        fin_at   = -1;
        for (int e = 1; e <= 400; e++) begin
            tick();
            start_b = 1'b0;
            cap[e]  = ser_b;
            if (fin_b) begin
                nfin++;
                if (fin_at < 0) fin_at = e;
            end
        end
        checkn("wide finish_at", 128'(fin_at), 128'd321);
        checkn("wide finish_count", 128'(nfin), 128'd1);
        check1("wide busy_end", busy_b, 1'b0);

        got_b = '0;
        pos   = 1;
        for (int k = 0; k < 16; k++) begin
            p = pos;
            while (p <= 400 && cap[p] !== 1'b0) p++;
            for (int j = 0; j < 8; j++) rx_byte[j] = cap[p + 2 * (1 + j) + 1];
            check1("wide stop", cap[p + 19], 1'b1);
            checkn("wide byte", 128'(rx_byte), 128'(exp_bytes.pop_front()));
            got_b = {got_b[119:0], rx_byte};
            pos   = p + 20;
        end
        checkn("wide word", got_b, word_b);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
